bitn_pio: RTL and testbench
===========================

BITN_PIO -- requirements
Module: bitn_pio

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of GPIO bits (1..8).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth (2..4).
REQ-003 SHALL have parameter EDGE_MODE, default 0, capture edge: 0 rising, 1 falling, 2 both.
REQ-004 SHALL have parameter RESET_OUT, default 0, reset value of the DATA register.
REQ-005 SHALL have port csi_clk  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port csi_reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port avs_s1_address  in  4  register word address.
REQ-008 SHALL have port avs_s1_read  in  1  read strobe.
REQ-009 SHALL have port avs_s1_readdata  out  8  registered read data.
REQ-010 SHALL have port avs_s1_write  in  1  write strobe.
REQ-011 SHALL have port avs_s1_writedata  in  8  write data.
REQ-012 SHALL have port coe_out  out  WIDTH  DATA register drive value.
REQ-013 SHALL have port coe_oe  out  WIDTH  output enable per bit (DIR register).
REQ-014 SHALL have port coe_in  in  WIDTH  asynchronous pin inputs.
REQ-015 SHALL have port ins_irq  out  1  level interrupt, active-high.

Function
REQ-016 Register map SHALL be: 0 DATA r/w; 1 SET w (DATA|=wd); 2 CLR w (DATA&=~wd); 3 TOGGLE w (DATA^=wd); 4 DIR r/w; 5 PIN r (synchronised coe_in); 6 EDGE r/w1c; 7 MASK r/w.
REQ-017 Writes SHALL use bits [WIDTH-1:0] of writedata; higher bits ignored.
REQ-018 Writes SHALL take effect on the clock edge sampling avs_s1_write; coe_out/coe_oe change the following cycle.
REQ-019 Read data SHALL appear on avs_s1_readdata one cycle after avs_s1_read (latency 1) and hold until the next read.
REQ-020 Bits [7:WIDTH] of read data, reads of write-only addresses 1-3, and addresses 8-15 SHALL return 0; writes to 5 and 8-15 SHALL be ignored.
REQ-021 Simultaneous read and write SHALL perform the write; read returns the pre-write value.
REQ-022 coe_in SHALL pass SYNC_STAGES flops before PIN, edge logic or any other use.
REQ-023 EDGE bit n SHALL set when synchronised bit n shows the EDGE_MODE transition between consecutive cycles.
REQ-024 Writing 1 to EDGE bit n SHALL clear it; a new edge in the same cycle SHALL win (bit stays 1).
REQ-025 ins_irq SHALL be registered: high the cycle after |(EDGE & MASK) becomes nonzero, low the cycle after it becomes zero.

Reset
REQ-026 On csi_reset: DATA=RESET_OUT, DIR=0, EDGE=0, MASK=0, readdata=0, ins_irq=0, synchroniser flops=0.
REQ-027 Edge detection SHALL be suppressed for SYNC_STAGES+1 cycles after reset release; no spurious EDGE bits.
REQ-028 Reset asserted mid-access SHALL discard the access; reset SHALL dominate write strobes.

Configuration
REQ-029 Macro BITN_PIO_IRQ_EN SHALL compile in EDGE, MASK and ins_irq logic.
REQ-030 Without BITN_PIO_IRQ_EN: addresses 6-7 read 0 and ignore writes, ins_irq tied 0, no edge flops synthesised.

Structure
REQ-031 Package bitn_pio_pkg SHALL hold register address constants (ADDR_DATA..ADDR_MASK) and EDGE_MODE constants (EDGE_RISE, EDGE_FALL, EDGE_BOTH).
REQ-032 Sub-module bitn_sync SHALL implement the per-bit synchroniser chain plus edge-detect pulse, instantiated WIDTH times.
REQ-033 Implementation SHALL be 120-400 lines of RTL.

Verification
REQ-034 Reset with RESET_OUT=8'hA5 -> coe_out=A5, coe_oe=00, ins_irq=0; read addr 0 -> A5 one cycle later.
REQ-035 DATA=0F; SET F0 -> FF; CLR 11 -> EE; TOGGLE FF -> 11; each visible on coe_out next cycle.
REQ-036 WIDTH=4: write addr 0 data FF -> readback 0F; read addr 9 -> 00; write addr 5 -> no state change.
REQ-037 EDGE_MODE=0, MASK=01, coe_in[0] 0->1 -> EDGE=01 after SYNC_STAGES+1 cycles, ins_irq high next cycle; W1C 01 -> ins_irq low.
REQ-038 W1C of EDGE bit 0 coincident with new rising edge on bit 0 -> EDGE bit 0 remains 1, ins_irq stays high.
REQ-039 Build without BITN_PIO_IRQ_EN; toggle coe_in -> ins_irq=0, reads of 6/7 return 00.

Source files
------------

// File: rtl/bitn_pio_pkg.sv
// Shared register map and edge-mode constants for the bitn_pio GPIO block.
// Interrupt/edge support is compiled in by defining BITN_PIO_IRQ_EN.
package bitn_pio_pkg;

    typedef enum logic [3:0] {
        ADDR_DATA   = 4'd0,
        ADDR_SET    = 4'd1,
        ADDR_CLR    = 4'd2,
        ADDR_TOGGLE = 4'd3,
        ADDR_DIR    = 4'd4,
        ADDR_PIN    = 4'd5,
        ADDR_EDGE   = 4'd6,
        ADDR_MASK   = 4'd7
    } reg_addr_e;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_BOTH = 2;

    function automatic logic edge_hit(input int unsigned mode, input logic cur, input logic prev);
        logic hit;
        hit = 1'b0;
        case (mode)
            EDGE_RISE: hit = cur & ~prev;
            EDGE_FALL: hit = ~cur & prev;
            default:   hit = cur ^ prev;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/bitn_sync.sv
// Per-bit input synchroniser chain with optional edge-detect pulse.
// The edge flop and pulse exist only when BITN_PIO_IRQ_EN is defined.
module bitn_sync
    import bitn_pio_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_MODE   = EDGE_RISE
) (
    input  logic csi_clk,
    input  logic csi_reset,
    input  logic din,
`ifdef BITN_PIO_IRQ_EN
    input  logic arm,
    output logic edge_pulse,
`endif
    output logic dout
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge csi_clk) begin
        if (csi_reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
        end
    end

    assign dout = chain[SYNC_STAGES-1];

`ifdef BITN_PIO_IRQ_EN
    logic prev;

    always_ff @(posedge csi_clk) begin
        if (csi_reset) begin
            prev <= 1'b0;
        end else begin
            prev <= dout;
        end
    end

    always_comb begin
        edge_pulse = arm & edge_hit(EDGE_MODE, dout, prev);
    end
`endif

endmodule

// File: rtl/bitn_pio.sv
// Avalon-MM GPIO port: DATA/SET/CLR/TOGGLE/DIR/PIN registers, plus EDGE/MASK
// and a level interrupt when built with BITN_PIO_IRQ_EN.
module bitn_pio
    import bitn_pio_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_MODE   = EDGE_RISE,
    parameter int unsigned RESET_OUT   = 0
) (
    input  logic             csi_clk,
    input  logic             csi_reset,
    input  logic [3:0]       avs_s1_address,
    input  logic             avs_s1_read,
    output logic [7:0]       avs_s1_readdata,
    input  logic             avs_s1_write,
    input  logic [7:0]       avs_s1_writedata,
    output logic [WIDTH-1:0] coe_out,
    output logic [WIDTH-1:0] coe_oe,
    input  logic [WIDTH-1:0] coe_in,
    output logic             ins_irq
);

    localparam logic [7:0] RESET_BYTE = 8'(RESET_OUT);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] pin_sync;
    logic [WIDTH-1:0] wd;
    logic [7:0]       rd_word;

    assign wd      = avs_s1_writedata[WIDTH-1:0];
    assign coe_out = data_q;
    assign coe_oe  = dir_q;

`ifdef BITN_PIO_IRQ_EN
    localparam logic [2:0] ARM_DELAY = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] w1c;
    logic [2:0]       arm_cnt;
    logic             arm;

    // Hold edge capture off until the synchroniser and edge flop have
    // flushed their reset zeros, so a pin already high reads as no event.
    always_ff @(posedge csi_clk) begin
        if (csi_reset) begin
            arm_cnt <= ARM_DELAY;
        end else if (arm_cnt != '0) begin
            arm_cnt <= arm_cnt - 3'd1;
        end
    end

    assign arm = (arm_cnt == '0);
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_sync
        bitn_sync #(
            .SYNC_STAGES(SYNC_STAGES),
            .EDGE_MODE  (EDGE_MODE)
        ) u_sync (
            .csi_clk   (csi_clk),
            .csi_reset (csi_reset),
            .din       (coe_in[i]),
`ifdef BITN_PIO_IRQ_EN
            .arm       (arm),
            .edge_pulse(edge_pulse[i]),
`endif
            .dout      (pin_sync[i])
        );
    end

    always_ff @(posedge csi_clk) begin
        if (csi_reset) begin
            data_q <= RESET_BYTE[WIDTH-1:0];
            dir_q  <= '0;
        end else if (avs_s1_write) begin
            case (avs_s1_address)
                ADDR_DATA:   data_q <= wd;
                ADDR_SET:    data_q <= data_q | wd;
                ADDR_CLR:    data_q <= data_q & ~wd;
                ADDR_TOGGLE: data_q <= data_q ^ wd;
                ADDR_DIR:    dir_q  <= wd;
                default:     ;
            endcase
        end
    end

    always_comb begin
        rd_word = '0;
        case (avs_s1_address)
            ADDR_DATA: rd_word[WIDTH-1:0] = data_q;
            ADDR_DIR:  rd_word[WIDTH-1:0] = dir_q;
            ADDR_PIN:  rd_word[WIDTH-1:0] = pin_sync;
`ifdef BITN_PIO_IRQ_EN
            ADDR_EDGE: rd_word[WIDTH-1:0] = edge_q;
            ADDR_MASK: rd_word[WIDTH-1:0] = mask_q;
`endif
            default:   ;
        endcase
    end

    always_ff @(posedge csi_clk) begin
        if (csi_reset) begin
            avs_s1_readdata <= '0;
        end else if (avs_s1_read) begin
            avs_s1_readdata <= rd_word;
        end
    end

`ifdef BITN_PIO_IRQ_EN
    always_comb begin
        w1c = '0;
        if (avs_s1_write && avs_s1_address == ADDR_EDGE) begin
            w1c = wd;
        end
    end

    // A fresh edge is OR-ed in after the clear so it survives a same-cycle W1C.
    always_ff @(posedge csi_clk) begin
        if (csi_reset) begin
            edge_q  <= '0;
            mask_q  <= '0;
            ins_irq <= 1'b0;
        end else begin
            edge_q <= (edge_q & ~w1c) | edge_pulse;
            if (avs_s1_write && avs_s1_address == ADDR_MASK) begin
                mask_q <= wd;
            end
            ins_irq <= |(edge_q & mask_q);
        end
    end
`else
    assign ins_irq = 1'b0;
`endif

endmodule

// File: tb/tb_bitn_pio.sv
// Directed self-checking bench for bitn_pio; the EDGE/MASK/irq section
// follows whether BITN_PIO_IRQ_EN is defined for the build.
module tb_bitn_pio;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [3:0] addr8 = '0;
    logic       rd8_en = 1'b0;
    logic       wr8_en = 1'b0;
    logic [7:0] wd8 = '0;
    logic [7:0] rd8;
    logic [7:0] out8;
    logic [7:0] oe8;
    logic [7:0] in8 = 8'h5A;
    logic       irq8;

    logic [3:0] addr4 = '0;
    logic       rd4_en = 1'b0;
    logic       wr4_en = 1'b0;
    logic [7:0] wd4 = '0;
    logic [7:0] rd4;
    logic [3:0] out4;
    logic [3:0] oe4;
    logic [3:0] in4 = '0;
    logic       irq4;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    logic [7:0] q;

    always #5 clk = ~clk;

    bitn_pio #(
        .WIDTH      (8),
        .SYNC_STAGES(2),
        .EDGE_MODE  (0),
        .RESET_OUT  (8'hA5)
    ) u_dut (
        .csi_clk         (clk),
        .csi_reset       (rst),
        .avs_s1_address  (addr8),
        .avs_s1_read     (rd8_en),
        .avs_s1_readdata (rd8),
        .avs_s1_write    (wr8_en),
        .avs_s1_writedata(wd8),
        .coe_out         (out8),
        .coe_oe          (oe8),
        .coe_in          (in8),
        .ins_irq         (irq8)
    );

    bitn_pio #(
        .WIDTH(4)
    ) u_dut4 (
        .csi_clk         (clk),
        .csi_reset       (rst),
        .avs_s1_address  (addr4),
        .avs_s1_read     (rd4_en),
        .avs_s1_readdata (rd4),
        .avs_s1_write    (wr4_en),
        .avs_s1_writedata(wd4),
        .coe_out         (out4),
        .coe_oe          (oe4),
        .coe_in          (in4),
        .ins_irq         (irq4)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called at a negedge; returns at the next negedge after the write edge.
    task automatic bus_wr(input bit n4, input logic [3:0] a, input logic [7:0] d);
        if (n4) begin
            addr4 = a; wd4 = d; wr4_en = 1'b1;
        end else begin
            addr8 = a; wd8 = d; wr8_en = 1'b1;
        end
        @(negedge clk);
        wr4_en = 1'b0;
        wr8_en = 1'b0;
    endtask

    task automatic bus_rd(input bit n4, input logic [3:0] a, output logic [7:0] d);
        if (n4) begin
            addr4 = a; rd4_en = 1'b1;
        end else begin
            addr8 = a; rd8_en = 1'b1;
        end
        @(negedge clk);
        rd4_en = 1'b0;
        rd8_en = 1'b0;
        d = n4 ? rd4 : rd8;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        // Reset state, checked while reset is still asserted
        idle(3);
        chk("rst_out", out8, 8'hA5);
        chk("rst_oe", oe8, 8'h00);
        chk("rst_irq", {7'd0, irq8}, 8'h00);
        chk("rst_rdata", rd8, 8'h00);
        rst = 1'b0;

        bus_rd(0, 4'd0, q);          chk("rd_data_rst", q, 8'hA5);

        bus_wr(0, 4'd0, 8'h0F);      chk("wr_data", out8, 8'h0F);
        bus_wr(0, 4'd1, 8'hF0);      chk("set", out8, 8'hFF);
        bus_wr(0, 4'd2, 8'h11);      chk("clr", out8, 8'hEE);
        bus_wr(0, 4'd3, 8'hFF);      chk("toggle", out8, 8'h11);

        bus_rd(0, 4'd1, q);          chk("rd_set_zero", q, 8'h00);
        bus_rd(0, 4'd12, q);         chk("rd_addr12", q, 8'h00);

        bus_wr(0, 4'd4, 8'h3C);      chk("dir_oe", oe8, 8'h3C);
        bus_rd(0, 4'd4, q);          chk("rd_dir", q, 8'h3C);

        bus_rd(0, 4'd5, q);          chk("rd_pin", q, 8'h5A);
        idle(2);                     chk("rd_hold", rd8, 8'h5A);

        // Simultaneous read and write of DATA: read sees the old value
        addr8 = 4'd0; wd8 = 8'h77; wr8_en = 1'b1; rd8_en = 1'b1;
        @(negedge clk);
        wr8_en = 1'b0; rd8_en = 1'b0;
        chk("rw_read_old", rd8, 8'h11);
        chk("rw_write", out8, 8'h77);

`ifdef BITN_PIO_IRQ_EN
        // Pin was 5A across reset release: no spurious edges
        bus_rd(0, 4'd6, q);          chk("edge_no_spurious", q, 8'h00);
        bus_wr(0, 4'd7, 8'h01);
        bus_rd(0, 4'd7, q);          chk("rd_mask", q, 8'h01);

        in8 = 8'h5B;
        idle(3);                     chk("irq_pre", {7'd0, irq8}, 8'h00);
        idle(1);                     chk("irq_rise", {7'd0, irq8}, 8'h01);
        bus_rd(0, 4'd6, q);          chk("edge_set", q, 8'h01);
        bus_wr(0, 4'd6, 8'h01);      chk("irq_w1c_lag", {7'd0, irq8}, 8'h01);
        idle(1);                     chk("irq_w1c_low", {7'd0, irq8}, 8'h00);
        bus_rd(0, 4'd6, q);          chk("edge_cleared", q, 8'h00);

        // Re-arm, then clear in the very cycle a new rising edge lands
        in8 = 8'h5A; idle(4);
        in8 = 8'h5B; idle(4);        chk("irq_rearm", {7'd0, irq8}, 8'h01);
        in8 = 8'h5A; idle(4);
        in8 = 8'h5B; idle(2);
        bus_wr(0, 4'd6, 8'h01);      chk("coinc_irq0", {7'd0, irq8}, 8'h01);
        idle(1);                     chk("coinc_irq1", {7'd0, irq8}, 8'h01);
        bus_rd(0, 4'd6, q);          chk("coinc_edge", q, 8'h01);
`else
        in8 = 8'hA5; idle(4);        chk("noirq_a", {7'd0, irq8}, 8'h00);
        in8 = 8'h5A; idle(4);        chk("noirq_b", {7'd0, irq8}, 8'h00);
        bus_wr(0, 4'd7, 8'hFF);
        bus_rd(0, 4'd7, q);          chk("noirq_rd7", q, 8'h00);
        bus_rd(0, 4'd6, q);          chk("noirq_rd6", q, 8'h00);
`endif

        // Narrow instance
        bus_wr(1, 4'd0, 8'hFF);      chk("w4_out", {4'h0, out4}, 8'h0F);
        bus_rd(1, 4'd0, q);          chk("w4_rd_data", q, 8'h0F);
        bus_rd(1, 4'd9, q);          chk("w4_rd_addr9", q, 8'h00);
        bus_wr(1, 4'd5, 8'h03);      chk("w4_pin_wr_oe", {4'h0, oe4}, 8'h00);
        bus_rd(1, 4'd0, q);          chk("w4_pin_wr_data", q, 8'h0F);

        // Reset dominates a concurrent write
        rst = 1'b1; addr8 = 4'd0; wd8 = 8'h00; wr8_en = 1'b1;
        @(negedge clk);
        rst = 1'b0; wr8_en = 1'b0;
        chk("rst_dom_out", out8, 8'hA5);
        chk("rst_dom_oe", oe8, 8'h00);
        chk("rst_dom_irq", {7'd0, irq8}, 8'h00);
        chk("rst_dom_rdata", rd8, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
